// File: rtl/fadd_rr_scheduler.sv
// Round-robin scheduler sharing one combinational single-precision adder among N_REQ
// requesters. Define FADD_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).

module float_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic        swap;
    logic [31:0] x, y;
    logic        big_s, small_s;
    logic [7:0]  big_e, small_e;
    logic [7:0]  eff_big_e, eff_small_e;
    logic [7:0]  diff_e;
    logic [23:0] big_m, small_m;
    logic [26:0] big_x, small_x, shifted;
    logic        sticky;
    logic [27:0] raw;
    logic [26:0] norm;
    logic [9:0]  exp_w;
    logic [4:0]  lz, shamt;
    logic        found;
    logic        round_up;
    logic [24:0] rnd;
    logic [23:0] mant;

    always_comb begin
        sum         = '0;
        swap        = (b[30:0] > a[30:0]);
        x           = swap ? b : a;
        y           = swap ? a : b;
        big_s       = x[31];
        small_s     = y[31];
        big_e       = x[30:23];
        small_e     = y[30:23];
        big_m       = {|big_e, x[22:0]};
        small_m     = {|small_e, y[22:0]};
        // subnormals share the exponent of the smallest normal
        eff_big_e   = (big_e == 8'd0) ? 8'd1 : big_e;
        eff_small_e = (small_e == 8'd0) ? 8'd1 : small_e;
        diff_e      = eff_big_e - eff_small_e;
        big_x       = {big_m, 3'b000};
        small_x     = {small_m, 3'b000};
        shifted     = '0;
        sticky      = 1'b0;
        if (diff_e >= 8'd27) begin
            small_x = {26'd0, |small_m};
        end else begin
            shifted = small_x >> diff_e;
            sticky  = |(small_x & ~({27{1'b1}} << diff_e));
            small_x = {shifted[26:1], shifted[0] | sticky};
        end

        if (big_s == small_s)
            raw = {1'b0, big_x} + {1'b0, small_x};
        else
            raw = {1'b0, big_x} - {1'b0, small_x};

        exp_w = {2'b00, eff_big_e};
        lz    = '0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (raw[i])
                    found = 1'b1;
                else
                    lz = lz + 5'd1;
            end
        end

        shamt = '0;
        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_w = exp_w + 10'd1;
        end else begin
            // never shift below the minimum exponent: the result becomes subnormal
            if ({5'd0, lz} < exp_w - 10'd1)
                shamt = lz;
            else
                shamt = 5'(exp_w - 10'd1);
            norm  = raw[26:0] << shamt;
            exp_w = exp_w - {5'd0, shamt};
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            mant  = rnd[24:1];
            exp_w = exp_w + 10'd1;
        end else begin
            mant  = rnd[23:0];
        end

        if (big_e == 8'hFF) begin
            sum = (small_e == 8'hFF && big_s != small_s) ? 32'h7FC0_0000 : x;
        end else if (raw == 28'd0) begin
            sum = {big_s & small_s, 31'd0};
        end else if (exp_w >= 10'd255) begin
            sum = {big_s, 8'hFF, 23'd0};
        end else begin
            sum = {big_s, (mant[23] ? exp_w[7:0] : 8'd0), mant[22:0]};
        end
    end
endmodule

module fadd_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  a_in,
    input  logic [32*N_REQ-1:0]  b_in,
    output logic [N_REQ-1:0]     gnt,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [ID_W-1:0]      res_id
);
    logic [31:0]     a_arr [N_REQ];
    logic [31:0]     b_arr [N_REQ];

    logic            s1_valid_reg;
    logic [31:0]     s1_a_reg;
    logic [31:0]     s1_b_reg;
    logic [ID_W-1:0] s1_id_reg;
    logic            res_valid_reg;
    logic [31:0]     res_data_reg;
    logic [ID_W-1:0] res_id_reg;

    logic            adv1, adv2;
    logic            grant_found;
    logic            grant_en;
    logic [ID_W-1:0] grant_idx;
    logic [31:0]     adder_sum;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign a_arr[gi] = a_in[32*gi +: 32];
            assign b_arr[gi] = b_in[32*gi +: 32];
            assign gnt[gi]   = grant_en && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign adv2     = s1_valid_reg & (~res_valid_reg | res_ready);
    assign adv1     = ~s1_valid_reg | adv2;
    assign grant_en = adv1 & grant_found;

`ifdef FADD_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] rr_ptr_next;

    // scan farthest-first so the requester nearest after rr_ptr overwrites the rest
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(rr_ptr_reg) + k) % N_REQ;
            if (req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    assign rr_ptr_next = grant_en ? grant_idx : rr_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_reg <= ID_W'(N_REQ - 1);
        else
            rr_ptr_reg <= rr_ptr_next;
    end
`endif

    float_adder u_float_adder (
        .a   (s1_a_reg),
        .b   (s1_b_reg),
        .sum (adder_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_id_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_id_reg    <= '0;
        end else begin
            if (grant_en) begin
                s1_valid_reg <= 1'b1;
                s1_a_reg     <= a_arr[grant_idx];
                s1_b_reg     <= b_arr[grant_idx];
                s1_id_reg    <= grant_idx;
            end else if (adv2) begin
                s1_valid_reg <= 1'b0;
            end

            // result register holds its contents while stalled
            if (adv2) begin
                res_valid_reg <= 1'b1;
                res_data_reg  <= adder_sum;
                res_id_reg    <= s1_id_reg;
            end else if (res_valid_reg && res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;
endmodule

// File: tb/tb_fadd_rr_scheduler.sv
// Scoreboard bench for fadd_rr_scheduler: directed vectors push expected results,
// a monitor pops and compares on every result handshake.

module tb_fadd_rr_scheduler;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] a_in;
    logic [32*N_REQ-1:0] b_in;
    logic [N_REQ-1:0]    gnt;
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         res_data;
    logic [ID_W-1:0]     res_id;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    fadd_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        a_in[32*i +: 32] = a;
        b_in[32*i +: 32] = b;
    endtask

    task automatic push_exp(input int id, input logic [31:0] data);
        exp_t e;
        e.id   = ID_W'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    // monitor: compares every accepted result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_result: got id=%0d data=%h expected none", res_id, res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result id=%0d data=%h (expected id=%0d data=%h)", res_id, res_data, e.id, e.data);
                check("res_id", 32'(res_id), 32'(e.id));
                check("res_data", res_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] eg;
        rst_n     = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        res_ready = 1'b0;

        // test 1: reset state, single request latency
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        rst_n = 1'b1;
        next_cycle();
        req = 4'b0001;
        set_ops(0, 32'h3F80_0000, 32'h4000_0000);
        res_ready = 1'b1;
        push_exp(0, 32'h4040_0000);
        @(negedge clk);
        check("t1_gnt_c0", 32'(gnt), 32'h1);
        check("t1_valid_c0", 32'(res_valid), 32'd0);
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        check("t1_valid_c1", 32'(res_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("t1_valid_c2", 32'(res_valid), 32'd1);
        next_cycle();
        repeat (2) next_cycle();

        // test 2: all requesting, round-robin order and back-to-back results
        do_reset();
        req  = 4'b1111;
        a_in = {4{32'h3FC0_0000}};
        b_in = {4{32'h3FC0_0000}};
        for (int c = 0; c < 5; c++) push_exp(c % 4, 32'h4040_0000);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            eg = 4'(1 << (c % 4));
            if (c < 5) check("t2_gnt", 32'(gnt), 32'(eg));
            if (c >= 2) check("t2_valid", 32'(res_valid), 32'd1);
            next_cycle();
            if (c == 4) req = 4'b0000;
        end

        // test 3 + 4: backpressure with two results in flight, waiting req2 (2.0 + -0.5)
        res_ready = 1'b0;
        req = 4'b0011;
        set_ops(0, 32'h3F80_0000, 32'h3F80_0000);
        set_ops(1, 32'h4000_0000, 32'h4000_0000);
        push_exp(1, 32'h4080_0000);
        push_exp(0, 32'h4000_0000);
        @(negedge clk);
        check("t3_gnt_first", 32'(gnt), 32'h2);
        next_cycle();
        req = 4'b0001;
        @(negedge clk);
        check("t3_gnt_second", 32'(gnt), 32'h1);
        next_cycle();
        req = 4'b0100;
        set_ops(2, 32'h4000_0000, 32'hBF00_0000);
        push_exp(2, 32'h3FC0_0000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_stall_gnt", 32'(gnt), 32'd0);
            check("t3_stall_valid", 32'(res_valid), 32'd1);
            check("t3_stall_data", res_data, 32'h4080_0000);
            check("t3_stall_id", 32'(res_id), 32'd1);
            next_cycle();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_resume_gnt", 32'(gnt), 32'h4);
        check("t3_drain0_valid", 32'(res_valid), 32'd1);
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        check("t3_drain1_valid", 32'(res_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t4_valid", 32'(res_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t3_idle_valid", 32'(res_valid), 32'd0);
        next_cycle();

        // test 5: asynchronous reset with both stages full
        res_ready = 1'b0;
        req = 4'b0001;
        set_ops(0, 32'h3F80_0000, 32'h3F80_0000);
        @(negedge clk);
        check("t5_gnt0", 32'(gnt), 32'h1);
        next_cycle();
        req = 4'b0010;
        @(negedge clk);
        check("t5_gnt1", 32'(gnt), 32'h2);
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        check("t5_full_valid", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_no_stale", 32'(res_valid), 32'd0);
            next_cycle();
        end
        req = 4'b1000;
        set_ops(3, 32'h3F80_0000, 32'h4000_0000);
        push_exp(3, 32'h4040_0000);
        @(negedge clk);
        check("t5_gnt3", 32'(gnt), 32'h8);
        next_cycle();
        req = 4'b0000;
        repeat (3) next_cycle();

        // test 6: two requesters held; arbitration policy depends on build
        req = 4'b0011;
        set_ops(0, 32'h3F80_0000, 32'h4000_0000);
        set_ops(1, 32'h4000_0000, 32'hBF00_0000);
        for (int c = 0; c < 4; c++) begin
`ifdef FADD_SCHED_FIXED_PRIO_EN
            push_exp(0, 32'h4040_0000);
            eg = 4'b0001;
`else
            push_exp(c % 2, (c % 2 == 0) ? 32'h4040_0000 : 32'h3FC0_0000);
            eg = 4'(1 << (c % 2));
`endif
            @(negedge clk);
            check("t6_gnt", 32'(gnt), 32'(eg));
            next_cycle();
        end
        req = 4'b0000;
        repeat (4) next_cycle();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
